// File: rtl/bounded_updown_counter_if.sv
// bounded_updown_counter_if: control and status bundle of the bounded up/down counter
interface bounded_updown_counter_if #(parameter int WIDTH = 4);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             at_max;
  logic             at_min;
  logic             wrap;
  modport master (output clr, load, load_val, en, up, limit, input q, at_max, at_min, wrap);
  modport slave (input clr, load, load_val, en, up, limit, output q, at_max, at_min, wrap);
endinterface

// File: rtl/bounded_updown_counter.sv
// bounded_updown_counter: up/down counter with programmable inclusive bound, saturate or wrap
module bounded_updown_counter #(
  parameter int WIDTH     = 4,
  parameter bit WRAP_MODE = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  bounded_updown_counter_if.slave bus
);
  logic [WIDTH-1:0] q_q, q_d, lim, ld;
  logic             wrap_q, wrap_d;
  assign lim = bus.limit;
  assign ld = (bus.load_val > lim) ? lim : bus.load_val;
  // next state: clr beats load beats en; compares happen before any add so q never overflows
  always_comb begin
    q_d = q_q;
    wrap_d = 1'b0;
    if (bus.clr) q_d = '0;
    else if (bus.load) q_d = ld;
    else if (bus.en && bus.up) begin
      if (q_q < lim) q_d = q_q + 1'b1;
      else if (WRAP_MODE) begin
        q_d = '0;
        wrap_d = 1'b1;
      end else q_d = lim;
    end else if (bus.en) begin
      if (q_q > lim) q_d = lim;
      else if (q_q != '0) q_d = q_q - 1'b1;
      else if (WRAP_MODE) begin
        q_d = lim;
        wrap_d = 1'b1;
      end
    end
  end
  // counter and wrap pulse registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.q = q_q;
  assign bus.wrap = wrap_q;
  assign bus.at_max = q_q >= lim;
  assign bus.at_min = q_q == '0;
endmodule

// File: tb/tb_bounded_updown_counter.sv
// tb_bounded_updown_counter: directed checks of saturate, wrap and wide variants
module tb_bounded_updown_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n = 0;
  int errs = 0;
  bounded_updown_counter_if #(.WIDTH(4)) ia ();
  bounded_updown_counter_if #(.WIDTH(4)) ib ();
  bounded_updown_counter_if #(.WIDTH(8)) ic ();
  bounded_updown_counter #(.WIDTH(4), .WRAP_MODE(1'b0)) u_a (.clk(clk), .reset(reset), .bus(ia.slave));
  bounded_updown_counter #(.WIDTH(4), .WRAP_MODE(1'b1)) u_b (.clk(clk), .reset(reset), .bus(ib.slave));
  bounded_updown_counter #(.WIDTH(8), .WRAP_MODE(1'b0)) u_c (.clk(clk), .reset(reset), .bus(ic.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {ia.clr, ia.load, ia.load_val, ia.en, ia.up} = '0;
    {ib.clr, ib.load, ib.load_val, ib.en, ib.up} = '0;
    {ic.clr, ic.load, ic.load_val, ic.en, ic.up} = '0;
    ia.limit = 4'd15;
    ib.limit = 4'd9;
    ic.limit = 8'hFF;
    #12;
    chk("rst_q", ia.q, 0);
    chk("rst_wrap", ia.wrap, 0);
    chk("rst_at_min", ia.at_min, 1);
    chk("rst_at_max", ia.at_max, 0);
    chk("rst_q_c", ic.q, 0);
    @(negedge clk);
    reset = 1'b0;
    ia.en = 1'b1;
    ia.up = 1'b1;
    ib.en = 1'b1;
    ib.up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("t1_q", ia.q, (i < 15) ? i : 15);
      chk("t1_at_max", ia.at_max, (i >= 15) ? 1 : 0);
      chk("t1_wrap", ia.wrap, 0);
      if (i <= 12) begin
        chk("t2_q", ib.q, i % 10);
        chk("t2_wrap", ib.wrap, (i == 10) ? 1 : 0);
        if (i == 12) ib.en = 1'b0;
      end
    end
    ia.en = 1'b0;
    ib.clr = 1'b1;
    tick();
    chk("t3_clr_q", ib.q, 0);
    chk("t3_clr_at_min", ib.at_min, 1);
    ib.clr = 1'b0;
    ib.limit = 4'd5;
    ib.up = 1'b0;
    ib.en = 1'b1;
    tick();
    chk("t3_q5", ib.q, 5);
    chk("t3_wrap5", ib.wrap, 1);
    chk("t3_at_min5", ib.at_min, 0);
    tick();
    chk("t3_q4", ib.q, 4);
    chk("t3_wrap4", ib.wrap, 0);
    tick();
    chk("t3_q3", ib.q, 3);
    chk("t3_wrap3", ib.wrap, 0);
    ib.limit = 4'd0;
    ib.up = 1'b1;
    #1;
    chk("lim0_at_max", ib.at_max, 1);
    tick();
    chk("lim0_up_q", ib.q, 0);
    chk("lim0_up_wrap", ib.wrap, 1);
    tick();
    chk("lim0_up2_wrap", ib.wrap, 1);
    ib.up = 1'b0;
    tick();
    chk("lim0_dn_q", ib.q, 0);
    chk("lim0_dn_wrap", ib.wrap, 1);
    ib.en = 1'b0;
    tick();
    chk("idle_wrap", ib.wrap, 0);
    ib.limit = 4'd15;
    ib.load = 1'b1;
    ib.load_val = 4'd14;
    tick();
    chk("full_load_q", ib.q, 14);
    ib.load = 1'b0;
    ib.en = 1'b1;
    ib.up = 1'b1;
    tick();
    chk("full_q15", ib.q, 15);
    tick();
    chk("full_wrap_q", ib.q, 0);
    chk("full_wrap", ib.wrap, 1);
    ib.en = 1'b0;
    ia.limit = 4'd10;
    ia.load = 1'b1;
    ia.load_val = 4'd13;
    tick();
    chk("t4_clamp_q", ia.q, 10);
    chk("t4_clamp_at_max", ia.at_max, 1);
    ia.clr = 1'b1;
    ia.load_val = 4'd3;
    tick();
    chk("t4_clr_wins", ia.q, 0);
    ia.clr = 1'b0;
    tick();
    chk("t4_load3", ia.q, 3);
    ia.limit = 4'd15;
    ia.load_val = 4'd12;
    tick();
    chk("t5_load12", ia.q, 12);
    ia.load = 1'b0;
    ia.limit = 4'd6;
    #1;
    chk("t5_at_max_now", ia.at_max, 1);
    tick();
    chk("t5_hold", ia.q, 12);
    ia.en = 1'b1;
    ia.up = 1'b0;
    tick();
    chk("t5_reenter_q", ia.q, 6);
    chk("t5_reenter_wrap", ia.wrap, 0);
    tick();
    chk("t5_dn5", ia.q, 5);
    ia.up = 1'b1;
    tick();
    chk("sat_up6", ia.q, 6);
    tick();
    chk("sat_hold6", ia.q, 6);
    ia.clr = 1'b1;
    tick();
    ia.clr = 1'b0;
    ia.up = 1'b0;
    tick();
    chk("sat_min_q", ia.q, 0);
    chk("sat_min_at_min", ia.at_min, 1);
    chk("sat_min_wrap", ia.wrap, 0);
    ia.en = 1'b0;
    ic.load = 1'b1;
    ic.load_val = 8'hFE;
    tick();
    ic.load = 1'b0;
    ic.en = 1'b1;
    ic.up = 1'b1;
    tick();
    chk("c_full_q", ic.q, 8'hFF);
    chk("c_full_at_max", ic.at_max, 1);
    tick();
    chk("c_full_hold", ic.q, 8'hFF);
    ic.en = 1'b0;
    ic.load = 1'b1;
    ic.load_val = 8'h37;
    tick();
    chk("t6_load", ic.q, 8'h37);
    ic.load = 1'b0;
    ic.en = 1'b1;
    tick();
    chk("t6_count", ic.q, 8'h38);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_q", ic.q, 0);
    chk("t6_async_wrap", ic.wrap, 0);
    chk("t6_async_at_min", ic.at_min, 1);
    tick();
    chk("t6_held_q", ic.q, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("t6_resume1", ic.q, 1);
    tick();
    chk("t6_resume2", ic.q, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
    $finish;
  end
endmodule
